// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: MSB-first serial receiver with a single-entry
// valid/ready output buffer and a sticky overflow flag.
// Optional feature macro: SERIAL_RX_PARITY_EN (appends one even-parity bit per
// frame and pulses parity_err when a frame arrives with bad parity).
module serial_to_parallel_rx #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    output logic             parity_err
);

`ifdef SERIAL_RX_PARITY_EN
    // Frame = WIDTH data bits + parity; all data bits are held when parity arrives.
    localparam int FRAME = WIDTH + 1;
    localparam int SH_W  = WIDTH;
`else
    // The last data bit comes straight from in_bit, so WIDTH-1 bits of storage suffice.
    localparam int FRAME = WIDTH;
    localparam int SH_W  = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    logic [SH_W-1:0]  r_shreg;
    logic [CNT_W-1:0] r_count;
    logic [SH_W:0]    w_shift;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_par_ok;
    logic             w_accept;
    logic [WIDTH-1:0] r_out_data;
    logic             r_overflow;
    buf_state_t       r_buf_state;
    buf_state_t       w_buf_next;
    logic             w_load;
    logic             w_drop;

    assign w_shift = {r_shreg, in_bit};
    // A start pulse realigns, so it can never complete a frame on the same edge.
    assign w_done  = in_valid && !start && (r_count == LAST);

`ifdef SERIAL_RX_PARITY_EN
    logic r_parity_err;
    assign w_word     = r_shreg;
    assign w_par_ok   = ~^w_shift;
    assign parity_err = r_parity_err;

    // One-cycle error pulse following a frame whose parity did not check.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_parity_err <= 1'b0;
        else       r_parity_err <= w_done && !w_par_ok;
    end
`else
    assign w_word     = w_shift;
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign w_accept = w_done && w_par_ok;

    // Shift register and bit counter; start discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (start) begin
            r_shreg <= in_valid ? SH_W'(in_bit) : '0;
            r_count <= in_valid ? CNT_W'(1) : '0;
        end else if (in_valid) begin
            r_shreg <= w_shift[SH_W-1:0];
            r_count <= w_done ? '0 : r_count + CNT_W'(1);
        end
    end

    // Output buffer next state: a completion loads unless the held word is
    // still unconsumed, in which case it is dropped.
    always_comb begin
        w_buf_next = r_buf_state;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        case (r_buf_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_load     = 1'b1;
                    w_buf_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (w_accept) begin
                    if (out_ready) w_load = 1'b1;
                    else           w_drop = 1'b1;
                end else if (out_ready) begin
                    w_buf_next = BUF_EMPTY;
                end
            end
            default: w_buf_next = BUF_EMPTY;
        endcase
    end

    // Buffer state, held word and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_state <= BUF_EMPTY;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_buf_state <= w_buf_next;
            if (w_load) r_out_data <= w_word;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = (r_buf_state == BUF_FULL);
    assign busy      = (r_count != '0);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Testbench for serial_to_parallel_rx: directed plus random traffic checked
// against a queue-based reference model of frames and the output buffer.
module tb_serial_to_parallel_rx;
    localparam int W = 32;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = W + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         reset, start, in_valid, in_bit, out_ready;
    logic [W-1:0] out_data;
    logic         out_valid, busy, overflow, parity_err;

    serial_to_parallel_rx #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_bit(in_bit), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overflow(overflow),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: received bits of the current frame plus buffer contents.
    bit           m_bits[$];
    logic [W-1:0] m_data;
    bit           m_valid, m_ovf, m_perr;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  out_data,   m_data);
        chk({tag, ".valid"}, out_valid,  m_valid);
        chk({tag, ".busy"},  busy,       m_bits.size() != 0);
        chk({tag, ".ovf"},   overflow,   m_ovf);
        chk({tag, ".perr"},  parity_err, m_perr);
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit iv, input bit ib, input bit rdy);
        bit           old_valid;
        bit           p;
        bit           ok;
        logic [W-1:0] w;
        old_valid = m_valid;
        m_perr    = 1'b0;
        if (old_valid && rdy) m_valid = 1'b0;
        if (st) begin
            m_bits.delete();
            if (iv) m_bits.push_back(ib);
        end else if (iv) begin
            m_bits.push_back(ib);
            if (m_bits.size() == FRAME) begin
                w = '0;
                p = 1'b0;
                for (int i = 0; i < W; i++) w = (w << 1) | W'(m_bits[i]);
                foreach (m_bits[i]) p ^= m_bits[i];
                ok = !PAR || !p;
                m_bits.delete();
                if (ok) begin
                    if (!old_valid || rdy) begin
                        m_data  = w;
                        m_valid = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else begin
                    m_perr = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input bit st, input bit iv, input bit ib, input bit rdy, input string tag);
        start     = st;
        in_valid  = iv;
        in_bit    = ib;
        out_ready = rdy;
        @(posedge clk);
        model_edge(st, iv, ib, rdy);
        #1;
        check_all(tag);
    endtask

    // Sends bits w[first:0] MSB first (plus parity when enabled); out_ready is
    // raised only on the frame's final edge when rdy_last is set.
    task automatic send_frame(input logic [W-1:0] w, input int first, input bit rdy_last,
                              input bit bad_par, input string tag);
        bit p;
        p = (^w) ^ bad_par;
        for (int i = first; i >= 0; i--)
`ifdef SERIAL_RX_PARITY_EN
            step(1'b0, 1'b1, w[i], 1'b0, tag);
        step(1'b0, 1'b1, p, rdy_last, tag);
`else
            step(1'b0, 1'b1, w[i], (i == 0) ? rdy_last : 1'b0, tag);
`endif
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        int           g;
        bit           bad, b;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check_all("reset_hold");
        #9;
        reset = 1'b0;
        step(0, 0, 0, 0, "idle");
        step(0, 0, 0, 1, "idle_rdy");
        chk("idle_const_valid", out_valid, 1'b0);

        // Single word, consumer stalled.
        send_frame(32'hA5A5F00F, W - 1, 1'b0, 1'b0, "a5");
        chk("a5_const_data", out_data, 32'hA5A5F00F);
        chk("a5_const_busy", busy, 1'b0);
        step(0, 0, 0, 1, "drain");

        // Word with a three-cycle gap at a random position, then one pop.
        d = 32'h12345678;
        g = $urandom_range(1, W - 2);
        for (int i = W - 1; i >= 0; i--) begin
            if (i == g) repeat (3) step(0, 0, 0, 0, "gap");
            step(0, 1, d[i], 0, "gapw");
        end
`ifdef SERIAL_RX_PARITY_EN
        step(0, 1, ^d, 0, "gapw_par");
`endif
        chk("gap_const_data", out_data, 32'h12345678);
        step(0, 0, 0, 1, "pop");
        chk("pop_const_valid", out_valid, 1'b0);

        // Back-to-back words with the buffer never drained -> overflow.
        pulse_reset("rst_ovf");
        send_frame(32'h00000001, W - 1, 1'b0, 1'b0, "b2b1");
        send_frame(32'hFFFFFFFF, W - 1, 1'b0, 1'b0, "b2b2");
        chk("ovf_const_data", out_data, 32'h00000001);
        chk("ovf_const_flag", overflow, 1'b1);

        // Same pair, consumer ready on the second completion edge.
        pulse_reset("rst_noovf");
        send_frame(32'h00000001, W - 1, 1'b0, 1'b0, "b2b1r");
        send_frame(32'hFFFFFFFF, W - 1, 1'b1, 1'b0, "b2b2r");
        chk("noovf_const_data", out_data, 32'hFFFFFFFF);
        chk("noovf_const_flag", overflow, 1'b0);

        // Garbage, then start carrying bit 31 of the new word.
        repeat (10) step(0, 1, 1'($urandom_range(0, 1)), 0, "garbage");
        step(1, 1, 1, 0, "start");
        send_frame(32'hDEADBEEF, W - 2, 1'b1, 1'b0, "dead");
        chk("dead_const_data", out_data, 32'hDEADBEEF);

        // Asynchronous reset in the middle of a word.
        repeat (20) step(0, 1, 1'($urandom_range(0, 1)), 0, "partial");
        reset = 1'b1;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_valid", out_valid, 1'b0);
        model_reset();
        check_all("async_rst");
        #1;
        reset = 1'b0;

        // Random traffic: gaps, random consumer, occasional bad parity.
        for (int n = 0; n < 10; n++) begin
            d   = $urandom;
            bad = PAR && ($urandom_range(0, 3) == 0);
            for (int k = 0; k < FRAME; k++) begin
                b = (k < W) ? d[W - 1 - k] : ((^d) ^ bad);
                if ($urandom_range(0, 3) == 0) step(0, 0, 0, 1'($urandom_range(0, 1)), "rgap");
                step(0, 1, b, 1'($urandom_range(0, 1)), "rnd");
            end
        end

`ifdef SERIAL_RX_PARITY_EN
        pulse_reset("rst_par");
        send_frame(32'h0000000F, W - 1, 1'b0, 1'b0, "par_good");
        chk("par_good_valid", out_valid, 1'b1);
        chk("par_good_data", out_data, 32'h0000000F);
        send_frame(32'h0000000F, W - 1, 1'b0, 1'b1, "par_bad");
        chk("par_bad_pulse", parity_err, 1'b1);
        chk("par_bad_valid", out_valid, 1'b1);
        chk("par_bad_ovf", overflow, 1'b0);
        step(0, 0, 0, 0, "par_after");
        chk("par_pulse_end", parity_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
